// File: rtl/key_loader_pkg.sv
// Shared types and CRC-8 helper for the serial key loader.
// Polynomial x^8+x^2+x+1, init 0x00, no reflection, no final XOR.
package key_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StCheck,
        StArmed,
        StLockout
    } state_e;

    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] CRC_INIT = 8'h00;

    // One bit of the serial CRC-8, MSB-first shift register form.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/key_loader_serial_if.sv
// Handshake and key-delivery bundle between the provisioning source, the loader
// and the locked core. master = source/consumer side, slave = loader.
interface key_loader_serial_if #(
    parameter int unsigned KEY_W = 32
);
    logic             load_start_i;
    logic             key_bit_i;
    logic             key_valid_i;
    logic             key_ready_o;
    logic [KEY_W-1:0] keyinput_o;
    logic             key_armed_o;
    logic             key_err_o;
    logic             busy_o;
    logic             locked_out_o;

    modport master (
        output load_start_i, key_bit_i, key_valid_i,
        input  key_ready_o, keyinput_o, key_armed_o, key_err_o, busy_o, locked_out_o
    );

    modport slave (
        input  load_start_i, key_bit_i, key_valid_i,
        output key_ready_o, keyinput_o, key_armed_o, key_err_o, busy_o, locked_out_o
    );
endinterface

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator (poly 0x07) with synchronous clear.
module crc8_serial
    import key_loader_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear,
    input  logic       enable,
    input  logic       din,
    output logic [7:0] crc
);

    // Accumulate one message bit per enabled cycle; clear wins over enable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc <= CRC_INIT;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (enable) begin
            crc <= crc8_step(crc, din);
        end
    end

endmodule

// File: rtl/key_loader_serial.sv
// Serial key loader: receives KEY_W key bits (LSB first) followed by a CRC-8
// (MSB first), verifies the CRC and presents the key as a held parallel bus.
// Optional lockout after MAX_FAIL consecutive CRC failures: KEY_LOADER_LOCKOUT_EN.
module key_loader_serial
    import key_loader_pkg::*;
#(
    parameter int unsigned KEY_W    = 32,
    parameter int unsigned CRC_W    = 8,
    parameter int unsigned MAX_FAIL = 3
) (
    input logic          clk_i,
    input logic          rst_i,
    key_loader_serial_if.slave bus
);

    localparam int unsigned FRAME_W = KEY_W + CRC_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] KEY_BEATS = CNT_W'(KEY_W);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_W - 1);

    // The CRC engine is hard-wired to 8 bits; a zero fail limit is meaningless.
    if (CRC_W != 8 || MAX_FAIL == 0) begin : g_param_check
        $error("key_loader_serial: CRC_W must be 8 and MAX_FAIL nonzero");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [KEY_W-1:0]   key_sr_q, key_sr_d;
    logic [CRC_W-1:0]   crc_rx_q, crc_rx_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               armed_q, armed_d;
    logic               err_q, err_d;
    logic               crc_clear;
    logic               crc_en;
    logic [7:0]         crc_calc;
    logic               transfer;

`ifdef KEY_LOADER_LOCKOUT_EN
    localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);
    logic [FAIL_W-1:0]  fail_q, fail_d, fail_next;
`endif

    assign transfer = bus.key_valid_i && (state_q == StShift);

    crc8_serial u_crc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (crc_clear),
        .enable (crc_en),
        .din    (bus.key_bit_i),
        .crc    (crc_calc)
    );

    // Next-state, datapath and CRC-engine control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_sr_d  = key_sr_q;
        crc_rx_d  = crc_rx_q;
        key_d     = key_q;
        armed_d   = armed_q;
        err_d     = 1'b0;
        crc_clear = 1'b0;
        crc_en    = 1'b0;
`ifdef KEY_LOADER_LOCKOUT_EN
        fail_d    = fail_q;
        fail_next = (fail_q == FAIL_MAX) ? fail_q : fail_q + 1'b1;
`endif
        case (state_q)
            StIdle, StArmed: begin
                // Re-keying keeps the armed key visible until CHECK decides.
                if (bus.load_start_i) begin
                    state_d   = StShift;
                    cnt_d     = '0;
                    crc_clear = 1'b1;
                end
            end
            StShift: begin
                if (transfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q < KEY_BEATS) begin
                        key_sr_d = {bus.key_bit_i, key_sr_q[KEY_W-1:1]};
                        crc_en   = 1'b1;
                    end else begin
                        crc_rx_d = {crc_rx_q[CRC_W-2:0], bus.key_bit_i};
                    end
                    if (cnt_q == LAST_BEAT) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (crc_calc == crc_rx_q) begin
                    key_d   = key_sr_q;
                    armed_d = 1'b1;
                    state_d = StArmed;
`ifdef KEY_LOADER_LOCKOUT_EN
                    fail_d  = '0;
`endif
                end else begin
                    // A bad frame revokes any previously armed key.
                    err_d   = 1'b1;
                    key_d   = '0;
                    armed_d = 1'b0;
`ifdef KEY_LOADER_LOCKOUT_EN
                    fail_d  = fail_next;
                    state_d = (fail_next == FAIL_MAX) ? StLockout : StIdle;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef KEY_LOADER_LOCKOUT_EN
            StLockout: begin
                key_d   = '0;
                armed_d = 1'b0;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            key_sr_q <= '0;
            crc_rx_q <= '0;
            key_q    <= '0;
            armed_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef KEY_LOADER_LOCKOUT_EN
            fail_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_sr_q <= key_sr_d;
            crc_rx_q <= crc_rx_d;
            key_q    <= key_d;
            armed_q  <= armed_d;
            err_q    <= err_d;
`ifdef KEY_LOADER_LOCKOUT_EN
            fail_q   <= fail_d;
`endif
        end
    end

    // Moore status outputs decoded from the state register.
    always_comb begin
        bus.key_ready_o  = (state_q == StShift);
        bus.busy_o       = (state_q == StShift) || (state_q == StCheck);
        bus.keyinput_o   = key_q;
        bus.key_armed_o  = armed_q;
        bus.key_err_o    = err_q;
`ifdef KEY_LOADER_LOCKOUT_EN
        bus.locked_out_o = (state_q == StLockout);
`else
        bus.locked_out_o = 1'b0;
`endif
    end

endmodule
